// File: rtl/prmcu_uart_pkg.sv
`timescale 1ns/1ps
// Shared types for the UART receive path: FSM state, FIFO entry layout, widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prmcu_uart_pkg;

   localparam int DAT_W   = 9;
   localparam int NBITS_W = 4;
   localparam int NSTOP_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   typedef struct packed {
      logic             ferr;
      logic             perr;
      logic [DAT_W-1:0] dat;
   } rx_entry_t;

   localparam int ENTRY_W = $bits(rx_entry_t);

   // 2-of-3 vote used when majority sampling is built in
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/prmcu_sync_fifo.sv
`timescale 1ns/1ps
// Generic single-clock first-word-fall-through FIFO; rd_dat reads zero while empty.
// Latency: a written word is visible on rd_vld/rd_dat the cycle after the write.
// Backpressure: wr_rdy drops only when full and no read this cycle; rd_vld/rd_rdy handshake.
module prmcu_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_vld,
   input  logic [WIDTH-1:0]         wr_dat,
   output logic                     wr_rdy,
   output logic                     rd_vld,
   output logic [WIDTH-1:0]         rd_dat,
   input  logic                     rd_rdy,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             wr_fire;
   logic             rd_fire;

   assign full    = (count == (AW+1)'(DEPTH));
   assign rd_vld  = (count != '0);
   // A pop frees the slot in the same cycle, so a full FIFO still accepts a write alongside a read
   assign wr_rdy  = !full || rd_rdy;
   assign wr_fire = wr_vld && wr_rdy;
   assign rd_fire = rd_vld && rd_rdy;
   assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;
   assign level   = count;

   // Storage array, written at the tail
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_ptr] <= wr_dat;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_fire) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_fire, rd_fire})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/prmcu_uart_rx_fifo.sv
`timescale 1ns/1ps
// UART receiver (oversampled, 5..9 data bits, optional parity, 1..2 stop bits) feeding a FWFT receive FIFO.
// Latency: a word appears on out_vld_o one clk after its last stop-bit sample.
// Backpressure: out_vld_o/out_rdy_i handshake; a frame completing into a full FIFO is dropped and sets sticky overrun_o.
// Build option: define PRMCU_UART_RX_MAJORITY_EN for 2-of-3 majority voting around mid-bit.
module prmcu_uart_rx_fifo
   import prmcu_uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx_en,
   input  logic [NBITS_W-1:0]            n_data_bits_i,
   input  logic                          n_parity_bits_i,
   input  logic                          parity_odd_i,
   input  logic [NSTOP_W-1:0]            n_stop_bits_i,
   input  logic [DIV_W-1:0]              clk_divider_i,
   input  logic                          rx_i,
   output logic [DAT_W-1:0]              out_dat_o,
   output logic                          out_perr_o,
   output logic                          out_ferr_o,
   output logic                          out_vld_o,
   input  logic                          out_rdy_i,
   output logic                          overrun_o,
   input  logic                          overrun_clr_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          busy_o
);

   localparam int PH_W = $clog2(OVERSAMPLE);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
   localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2);
`ifdef PRMCU_UART_RX_MAJORITY_EN
   localparam logic [PH_W-1:0] PH_EARLY = PH_W'(OVERSAMPLE / 2 - 1);
   // Decide one tick after mid-bit, once the third vote is available
   localparam logic [PH_W-1:0] PH_DEC   = PH_W'(OVERSAMPLE / 2 + 1);
`else
   localparam logic [PH_W-1:0] PH_DEC   = PH_MID;
`endif

   rx_state_e            state;
   logic                 rx_s1, rx_s2, rx_prev;
   logic [DIV_W-1:0]     div_cnt, div_lat;
   logic [PH_W-1:0]      ph, ph_inc;
   logic                 tick, samp_evt, bit_val, start_go;
   logic [NBITS_W-1:0]   nbits_lat, bit_cnt;
   logic [NSTOP_W-1:0]   nstop_lat;
   logic                 par_en_lat, par_odd_lat, stop_cnt;
   logic [DAT_W-1:0]     data_q;
   logic                 perr_q, ferr_q;
   logic                 last_data, last_stop, push, fifo_wr_rdy;
   rx_entry_t            push_entry, head_entry;

   // Two-flop synchroniser plus one history flop for falling-edge detection; idle line is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx_i;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   assign start_go = (state == ST_IDLE) && rx_en && rx_prev && !rx_s2;
   assign tick     = (state != ST_IDLE) && (div_cnt == '0);
   assign ph_inc   = (ph == PH_LAST) ? '0 : ph + PH_W'(1);
   assign samp_evt = tick && (ph_inc == PH_DEC);

`ifdef PRMCU_UART_RX_MAJORITY_EN
   logic maj_a, maj_b;

   // Capture the two earlier votes; the third is the live synchronised line at the decision tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         maj_a <= 1'b1;
         maj_b <= 1'b1;
      end else if (tick) begin
         if (ph_inc == PH_EARLY) maj_a <= rx_s2;
         if (ph_inc == PH_MID)   maj_b <= rx_s2;
      end
   end

   assign bit_val = maj3(maj_a, maj_b, rx_s2);
`else
   assign bit_val = rx_s2;
`endif

   // Tick generator: one-clk pulse every clk_divider+1 clks, plus tick phase within the current bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         div_lat <= '0;
         ph      <= '0;
      end else if (start_go) begin
         div_cnt <= clk_divider_i;
         div_lat <= clk_divider_i;
         ph      <= '0;
      end else if (tick) begin
         div_cnt <= div_lat;
         ph      <= ph_inc;
      end else if (state != ST_IDLE) begin
         div_cnt <= div_cnt - DIV_W'(1);
      end
   end

   assign last_data = (bit_cnt == nbits_lat - NBITS_W'(1));
   assign last_stop = (nstop_lat != NSTOP_W'(2)) || stop_cnt;
   assign push      = samp_evt && (state == ST_STOP) && last_stop && rx_en;

   // Entry built from the registered fields plus the final stop-bit vote of this cycle
   always_comb begin
      push_entry      = '0;
      push_entry.ferr = ferr_q | ~bit_val;
      push_entry.perr = perr_q;
      push_entry.dat  = data_q;
   end

   // Frame FSM: start validation, LSB-first shift-in, parity check, stop-bit framing check
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         nbits_lat   <= '0;
         nstop_lat   <= '0;
         par_en_lat  <= 1'b0;
         par_odd_lat <= 1'b0;
         bit_cnt     <= '0;
         stop_cnt    <= 1'b0;
         data_q      <= '0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
      end else if (!rx_en) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_go) begin
                  state       <= ST_START;
                  nbits_lat   <= n_data_bits_i;
                  nstop_lat   <= n_stop_bits_i;
                  par_en_lat  <= n_parity_bits_i;
                  par_odd_lat <= parity_odd_i;
                  bit_cnt     <= '0;
                  stop_cnt    <= 1'b0;
                  data_q      <= '0;
                  perr_q      <= 1'b0;
                  ferr_q      <= 1'b0;
               end
            end
            ST_START: begin
               if (samp_evt) state <= bit_val ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
               if (samp_evt) begin
                  data_q[bit_cnt] <= bit_val;
                  bit_cnt         <= bit_cnt + NBITS_W'(1);
                  if (last_data) state <= par_en_lat ? ST_PARITY : ST_STOP;
               end
            end
            ST_PARITY: begin
               if (samp_evt) begin
                  perr_q <= (^data_q) ^ bit_val ^ par_odd_lat;
                  state  <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (samp_evt) begin
                  ferr_q   <= ferr_q | ~bit_val;
                  stop_cnt <= 1'b1;
                  if (last_stop) state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Sticky overrun: a completed frame the FIFO could not take; a new drop beats a clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_o <= 1'b0;
      end else if (push && !fifo_wr_rdy) begin
         overrun_o <= 1'b1;
      end else if (overrun_clr_i) begin
         overrun_o <= 1'b0;
      end
   end

   prmcu_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_vld (push),
      .wr_dat (push_entry),
      .wr_rdy (fifo_wr_rdy),
      .rd_vld (out_vld_o),
      .rd_dat (head_entry),
      .rd_rdy (out_rdy_i),
      .level  (fifo_level_o)
   );

   assign out_dat_o  = head_entry.dat;
   assign out_perr_o = head_entry.perr;
   assign out_ferr_o = head_entry.ferr;
   assign busy_o     = (state != ST_IDLE);

endmodule

// File: doc/prmcu_uart_rx_fifo.md
PRMCU_UART_RX_FIFO -- requirements
Module: prmcu_uart_rx_fifo

Interface
REQ-001 SHALL have parameters: OVERSAMPLE, default 16, ticks per bit (even, >=4); FIFO_DEPTH, default 8, entries (power of 2, >=2); DIV_W, default 16, tick-divider width.
REQ-002 SHALL have ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- rx_en  in  1  receiver enable
- n_data_bits_i  in  4  data bits, 5..9
- n_parity_bits_i  in  1  parity bit present
- parity_odd_i  in  1  1=odd, 0=even
- n_stop_bits_i  in  2  stop bits, 1..2
- clk_divider_i  in  DIV_W  clk cycles per tick minus 1
- rx_i  in  1  serial line
- out_dat_o  out  9  received word, zero-extended
- out_perr_o  out  1  parity error of head entry
- out_ferr_o  out  1  framing error of head entry
- out_vld_o  out  1  head entry valid
- out_rdy_i  in  1  consumer ready
- overrun_o  out  1  sticky overrun flag
- overrun_clr_i  in  1  clear overrun
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  entries held
- busy_o  out  1  frame in progress
REQ-003 SHALL use one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-004 rx_i SHALL pass a 2-flop synchroniser (reset value 1) before any use.
REQ-005 Tick counter SHALL count clk_divider_i down to 0, pulse tick for one clk, reload; it runs only when not IDLE.
REQ-006 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-007 IDLE->START on synchronised 1->0 with rx_en=1; config inputs latched at this cycle, tick and sample counters cleared.
REQ-008 START: sample at tick OVERSAMPLE/2; sample 1 -> IDLE, no entry (false start); sample 0 -> DATA.
REQ-009 DATA: sample every OVERSAMPLE ticks, LSB first, latched n_data_bits count; then PARITY if enabled, else STOP.
REQ-010 PARITY: perr = XOR(data bits, parity sample, parity_odd).
REQ-011 STOP: ferr set if any stop-bit sample is 0; at last stop sample push {ferr, perr, data} and -> IDLE same cycle, allowing back-to-back frames.
REQ-012 Handshake: pop when out_vld_o && out_rdy_i; out_vld_o rises the cycle after push into empty FIFO.
REQ-013 Push while full and no pop: entry dropped, overrun_o set; push and pop same cycle while full: both accepted, level unchanged.
REQ-014 overrun_o clears on overrun_clr_i; set and clear same cycle -> set wins.
REQ-015 rx_en=0 SHALL abort any frame to IDLE without push; FIFO contents retained and still readable.
REQ-016 busy_o = (state != IDLE).

Reset
REQ-017 On rst_n low: state IDLE, FIFO empty, out_vld_o=0, out_dat_o=0, out_perr_o=0, out_ferr_o=0, overrun_o=0, fifo_level_o=0, busy_o=0, synchroniser flops=1.

Configuration
REQ-018 PRMCU_UART_RX_MAJORITY_EN defined: each bit value = 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, /2, /2+1.
REQ-019 PRMCU_UART_RX_MAJORITY_EN undefined: single sample at tick OVERSAMPLE/2; no majority logic synthesised.

Structure
REQ-020 prmcu_uart_pkg SHALL hold FSM state enum, FIFO entry struct {ferr, perr, dat[8:0]}, and width constants.
REQ-021 FIFO SHALL be sub-module prmcu_sync_fifo (parametrised width/depth, first-word-fall-through).

Verification (clk 100 ns, OVERSAMPLE=16, clk_divider_i=4 -> 125000 baud, 8000 ns/bit)
REQ-022 8N1, rx frame 0xA5 -> one entry dat=0x0A5, perr=0, ferr=0, out_vld_o high after stop sample.
REQ-023 9-bit even parity, 0x1FF with parity bit 0 -> dat=0x1FF, perr=1; correct parity bit 1 -> perr=0.
REQ-024 8N2, second stop bit driven 0 -> dat correct, ferr=1.
REQ-025 out_rdy_i=0, FIFO_DEPTH+1 frames 0x01..0x09 -> level=8, overrun_o=1, contents 0x01..0x08 in order; overrun_clr_i pulse -> overrun_o=0.
REQ-026 4000 ns low glitch on idle line -> no entry, busy_o returns 0; rx_en dropped mid-DATA -> no entry, IDLE next cycle.
REQ-027 With PRMCU_UART_RX_MAJORITY_EN, one-clk inverted spike at mid-bit of 0x5A -> dat=0x05A; without macro, spike at exact sample tick corrupts that bit.
